// File: rtl/rr_mux_reg.sv
// N-channel arbitrated mux with a registered valid/ready output stage.
// Optional packet locking (in_last/out_last) is enabled by defining RR_MUX_PKT_LOCK_EN.
module rr_mux_reg #(
  parameter int WIDTH   = 8,
  parameter int NUM_CH  = 4,
  parameter int CH_W    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  parameter int RR_MODE = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
`ifdef RR_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]       in_last,
  output logic                    out_last,
`endif
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_chan,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [CH_W-1:0]   r_ptr;
  logic [CH_W-1:0]   r_chan;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;

  logic [CH_W-1:0]   w_base;
  logic [CH_W-1:0]   w_gidx;
  logic [CH_W-1:0]   w_nxt_ptr;
  logic [CH_W:0]     w_cand;
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_grant;
  logic [WIDTH-1:0]  w_sel;
  logic              w_found;
  logic              w_load;
  logic              w_xfer;

`ifdef RR_MUX_PKT_LOCK_EN
  logic              r_lock;
  logic [CH_W-1:0]   r_lock_ch;
  logic              r_last;
  logic              w_sel_last;

  // While a packet is open only its own channel may compete.
  assign w_mask     = r_lock ? (in_valid & (NUM_CH'(1) << r_lock_ch)) : in_valid;
  assign w_sel_last = in_last[w_gidx];
  assign out_last   = r_last;
`else
  assign w_mask = in_valid;
`endif

  assign w_base = (RR_MODE != 0) ? r_ptr : '0;

  // Scan channels starting at the base index, wrapping modulo NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cand = {1'b0, w_base} + (CH_W+1)'(k);
      if (w_cand >= (CH_W+1)'(NUM_CH))
        w_cand = w_cand - (CH_W+1)'(NUM_CH);
      if (!w_found && w_mask[w_cand[CH_W-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_cand[CH_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i])
        w_sel = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_grant   = w_found ? (NUM_CH'(1) << w_gidx) : '0;
  assign w_load    = !r_valid || out_ready;
  assign w_xfer    = w_found && w_load;
  assign in_ready  = w_grant & {NUM_CH{w_load}};
  assign w_nxt_ptr = (w_gidx == CH_W'(NUM_CH-1)) ? '0 : w_gidx + CH_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_sel;
        r_chan  <= w_gidx;
`ifdef RR_MUX_PKT_LOCK_EN
        if (w_sel_last)
          r_ptr <= w_nxt_ptr;
`else
        r_ptr   <= w_nxt_ptr;
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef RR_MUX_PKT_LOCK_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
    end else if (w_xfer) begin
      r_lock    <= !w_sel_last;
      r_lock_ch <= w_gidx;
      r_last    <= w_sel_last;
    end
  end
`endif

  assign out_data  = r_data;
  assign out_chan  = r_chan;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: round-robin (4 ch), fixed priority (4 ch), round-robin (3 ch).
module tb_rr_mux_reg;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Round-robin, 4 channels
  logic [31:0] a_data;
  logic [3:0]  a_valid, a_ready, a_last;
  logic [7:0]  a_odata;
  logic [1:0]  a_ochan;
  logic        a_ovalid, a_oready, a_olast;
  // Fixed priority, 4 channels
  logic [31:0] f_data;
  logic [3:0]  f_valid, f_ready, f_last;
  logic [7:0]  f_odata;
  logic [1:0]  f_ochan;
  logic        f_ovalid, f_oready, f_olast;
  // Round-robin, 3 channels
  logic [23:0] t_data;
  logic [2:0]  t_valid, t_ready, t_last;
  logic [7:0]  t_odata;
  logic [1:0]  t_ochan;
  logic        t_ovalid, t_oready, t_olast;

  rr_mux_reg #(.WIDTH(8), .NUM_CH(4), .RR_MODE(1)) u_rr (
    .clock(clock), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(a_last), .out_last(a_olast),
`endif
    .out_data(a_odata), .out_chan(a_ochan), .out_valid(a_ovalid), .out_ready(a_oready));

  rr_mux_reg #(.WIDTH(8), .NUM_CH(4), .RR_MODE(0)) u_fp (
    .clock(clock), .reset_n(reset_n), .in_data(f_data), .in_valid(f_valid),
    .in_ready(f_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(f_last), .out_last(f_olast),
`endif
    .out_data(f_odata), .out_chan(f_ochan), .out_valid(f_ovalid), .out_ready(f_oready));

  rr_mux_reg #(.WIDTH(8), .NUM_CH(3), .RR_MODE(1)) u_w3 (
    .clock(clock), .reset_n(reset_n), .in_data(t_data), .in_valid(t_valid),
    .in_ready(t_ready),
`ifdef RR_MUX_PKT_LOCK_EN
    .in_last(t_last), .out_last(t_olast),
`endif
    .out_data(t_odata), .out_chan(t_ochan), .out_valid(t_ovalid), .out_ready(t_oready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [1:0] c, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(a_ovalid), 32'(v));
    chk({tag, ".chan"},  32'(a_ochan),  32'(c));
    chk({tag, ".data"},  32'(a_odata),  32'(d));
  endtask

  initial begin
    a_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; a_valid = '0; a_oready = 1'b1; a_last = '1;
    f_data = {8'hB3, 8'hB2, 8'hB1, 8'hB0}; f_valid = '0; f_oready = 1'b1; f_last = '1;
    t_data = {8'hC2, 8'hC1, 8'hC0};        t_valid = '0; t_oready = 1'b1; t_last = '1;

    #1;
    chk_a("reset0", 1'b0, 2'd0, 8'h00);
    chk("reset0.fp_valid", 32'(f_ovalid), 32'd0);
    chk("reset0.w3_valid", 32'(t_ovalid), 32'd0);

    tick();
    reset_n = 1'b1;

    // Round-robin fairness, one word per cycle
    a_valid = 4'b1111;
    #1;
    chk("rr.ready0", 32'(a_ready), 32'h1);
    tick(); chk_a("rr.w0", 1'b1, 2'd0, 8'hA0);
    chk("rr.ready1", 32'(a_ready), 32'h2);
    tick(); chk_a("rr.w1", 1'b1, 2'd1, 8'hA1);
    tick(); chk_a("rr.w2", 1'b1, 2'd2, 8'hA2);
    tick(); chk_a("rr.w3", 1'b1, 2'd3, 8'hA3);
    tick(); chk_a("rr.w4", 1'b1, 2'd0, 8'hA0);

    // Backpressure: three stalled cycles
    a_oready = 1'b0;
    #1;
    chk("bp.ready_stall", 32'(a_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("bp.hold", 1'b1, 2'd0, 8'hA0);
      chk("bp.ready_hold", 32'(a_ready), 32'h0);
    end
    a_oready = 1'b1;
    #1;
    chk("bp.ready_release", 32'(a_ready), 32'h2);
    tick(); chk_a("bp.next", 1'b1, 2'd1, 8'hA1);

    // Idle drains the output, data/chan hold
    a_valid = 4'b0000;
    tick(); chk_a("idle", 1'b0, 2'd1, 8'hA1);

    // Asynchronous reset mid-stream
    a_valid = 4'b1111;
    tick(); chk_a("pre_rst", 1'b1, 2'd2, 8'hA2);
    reset_n = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 2'd0, 8'h00);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst.ready", 32'(a_ready), 32'h1);
    tick(); chk_a("post_rst.first", 1'b1, 2'd0, 8'hA0);
    a_valid = 4'b0000;
    tick();

    // Fixed priority: channel 3 never granted
    f_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fp.ready", 32'(f_ready), 32'h2);
      tick();
      chk("fp.chan", 32'(f_ochan), 32'd1);
      chk("fp.data", 32'(f_odata), 32'hB1);
    end
    f_valid = 4'b0000;
    tick();
    chk("fp.idle", 32'(f_ovalid), 32'd0);

    // Three channels: pointer wrap and sparse requests
    t_valid = 3'b010;
    tick(); chk("w3.c1", 32'(t_ochan), 32'd1);
    t_valid = 3'b001;
    #1;
    chk("w3.ready_c0", 32'(t_ready), 32'h1);
    tick();
    chk("w3.c0_chan", 32'(t_ochan), 32'd0);
    chk("w3.c0_data", 32'(t_odata), 32'hC0);
    t_valid = 3'b011;
    #1;
    chk("w3.ptr_is_1", 32'(t_ready), 32'h2);
    t_valid = 3'b100;
    tick(); chk("w3.c2", 32'(t_ochan), 32'd2);
    t_valid = 3'b111;
    #1;
    chk("w3.wrap_to_0", 32'(t_ready), 32'h1);
    t_valid = 3'b000;
    tick(); chk("w3.idle", 32'(t_ovalid), 32'd0);

`ifdef RR_MUX_PKT_LOCK_EN
    // Packet lock: ch1 sends 3 beats while ch2 stays valid (pointer is 1 here)
    a_valid = 4'b0110; a_last = 4'b0000;
    tick(); chk_a("lk.b0", 1'b1, 2'd1, 8'hA1); chk("lk.b0_last", 32'(a_olast), 32'd0);
    tick(); chk_a("lk.b1", 1'b1, 2'd1, 8'hA1); chk("lk.b1_last", 32'(a_olast), 32'd0);
    a_valid = 4'b0100;
    #1;
    chk("lk.gap_ready", 32'(a_ready), 32'h0);
    tick(); chk("lk.gap_valid", 32'(a_ovalid), 32'd0);
    a_valid = 4'b0110; a_last = 4'b0010;
    tick(); chk_a("lk.b2", 1'b1, 2'd1, 8'hA1); chk("lk.b2_last", 32'(a_olast), 32'd1);
    a_last = 4'b0100;
    tick(); chk_a("lk.next", 1'b1, 2'd2, 8'hA2); chk("lk.next_last", 32'(a_olast), 32'd1);
    a_valid = 4'b0000;
    tick();
    // Lock overrides fixed priority
    f_valid = 4'b1000; f_last = 4'b0000;
    tick(); chk("lk.fp_c3", 32'(f_ochan), 32'd3);
    f_valid = 4'b1010; f_last = 4'b1000;
    #1;
    chk("lk.fp_ready", 32'(f_ready), 32'h8);
    tick(); chk("lk.fp_c3_last", 32'(f_ochan), 32'd3);
    #1;
    chk("lk.fp_unlock", 32'(f_ready), 32'h2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the 2:1/4:1 gate muxes: N-channel, W-bit arbitrated multiplexer with valid/ready handshake on every input and on the output.
- Selects one requesting channel per cycle, either round-robin or fixed priority, and registers the winner's data plus channel index.
- Sits between keyboard/character sources and the shared display/compare path of the typing tutor.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_CH, 4, number of input channels (2..16).
- CH_W, clog2(NUM_CH) with minimum 1, width of channel-index output.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_CH  per-channel request.
- in_ready  out  NUM_CH  per-channel accept; combinational.
- out_data  out  WIDTH  registered selected data.
- out_chan  out  CH_W  registered index of the source channel.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset is asynchronous and active-low. While reset_n = 0: out_valid = 0, out_data = 0, out_chan = 0, RR pointer = 0.
- load = !out_valid | out_ready. The output register accepts a new word only when load = 1.
- Arbitration is combinational from in_valid and the pointer; at most one grant bit is set.
  - RR_MODE = 1: the first valid channel at or above the pointer wins, wrapping modulo NUM_CH.
  - RR_MODE = 0: the lowest-index valid channel wins; the pointer is ignored.
- in_ready[i] = grant[i] & load. A transfer occurs when in_valid[i] & in_ready[i].
- On a transfer from channel g at a clock edge:
  - out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - The pointer becomes (g+1) mod NUM_CH. When g = NUM_CH-1 it wraps to 0.
- If out_ready = 1 and no input is valid: out_valid <= 0; out_data and out_chan hold their last values.
- If out_valid = 1 and out_ready = 0: the output is stalled. out_* hold, all in_ready = 0, and the pointer holds.
- Simultaneous output accept and input transfer in the same cycle is allowed. This gives full throughput of one word per cycle and latency of 1 cycle from input transfer to out_valid.
- in_valid may drop without a transfer; the arbiter simply re-evaluates next cycle with no state change.
- Fairness: with all NUM_CH channels requesting continuously and out_ready = 1, the grant order is 0,1,...,NUM_CH-1,0,...
- NUM_CH not a power of 2: pointer values at or above NUM_CH are unreachable, and the wrap goes to 0.
- Reset asserted mid-stream: output is cleared immediately (asynchronously) and any word in flight is discarded.

Optional Feature:
- Macro: RR_MUX_PKT_LOCK_EN.
- Defined:
  - Adds port in_last (in, NUM_CH): end-of-packet marker per channel.
  - Adds state: lock flag plus locked channel index.
  - A transfer with in_last = 0 sets lock to that channel. While locked, only the locked channel can be granted, even if other channels are valid.
  - A transfer with in_last = 1 clears the lock and advances the pointer; the pointer does not advance on non-last beats.
  - Adds output out_last (registered alongside out_data).
  - Reset clears the lock.
- Undefined: no in_last/out_last ports, and arbitration happens independently on every transfer.

Test Plan:
- Reset: assert reset_n = 0 mid-transfer with out_valid = 1 -> out_valid = 0, out_data = 0, out_chan = 0 immediately, before the next clock edge. After release, channel 0 wins first.
- Round-robin fairness: NUM_CH = 4, all in_valid = 4'b1111, data = 8'hA0+i, out_ready = 1 -> out_chan sequence 0,1,2,3,0. out_data sequence A0,A1,A2,A3,A0, one word per cycle after 1-cycle latency.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> out_* stable and in_ready = 0. On out_ready = 1, the held word leaves and the next channel loads in the same cycle.
- Fixed priority: RR_MODE = 0, in_valid = 4'b1010 for 4 cycles -> out_chan = 1 every cycle and channel 3 never granted.
- Wrap and sparse requests: NUM_CH = 3, pointer = 2, in_valid = 3'b001 -> grant channel 0, next pointer = 1. Idle with out_ready = 1 -> out_valid falls to 0.
- Packet lock (RR_MUX_PKT_LOCK_EN): channel 1 sends 3 beats with in_last only on the third, while channel 2 is valid throughout -> out_chan = 1,1,1,2. out_last = 1 only on the third beat.
